// File: rtl/swd_arbiter.sv
// Two-way arbiter and sequencer sharing the SWD engine between the host link and
// the background poller; returns each result (or a timeout) to its owner.
module swd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned HOST_BURST     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_req,
    input  logic        h_write,
    input  logic        h_useParity,
    input  logic [4:0]  h_bits,
    input  logic [31:0] h_wdata,
    output logic        h_ack,
    output logic [31:0] h_rdata,
    output logic        h_rparity,
    output logic        h_timeout,
    input  logic        p_req,
    input  logic        p_write,
    input  logic        p_useParity,
    input  logic [4:0]  p_bits,
    input  logic [31:0] p_wdata,
    output logic        p_ack,
    output logic [31:0] p_rdata,
    output logic        p_rparity,
    output logic        p_timeout,
    output logic        rxReq,
    output logic        txReq,
    output logic        useParity,
    output logic [4:0]  bits,
    output logic [31:0] SWDinputData,
    input  logic [31:0] SWDoutputData,
    input  logic        SWDoutputParity,
    input  logic        SWDbusy,
    output logic        owner,
    output logic        active
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  BURST_LIM = 4'(HOST_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;

    state_t      state;
    logic        busy_meta;
    logic        busy_s;
    logic [3:0]  burst_cnt;
    logic [15:0] tmo_cnt;
    logic        own_write;

    logic        grant_poller;
    logic        finish;
    logic        res_timeout;
    logic [31:0] res_data;
    logic        res_parity;

    // Poller wins when it is alone or the host has used up its burst allowance.
    always_comb begin
        grant_poller = p_req && (!h_req || burst_cnt == BURST_LIM);
    end

    // Completion (normal or aborted) is decided here so the owner's result
    // registers are written from a single place in the sequential block.
    always_comb begin
        finish      = 1'b0;
        res_timeout = 1'b0;
        case (state)
            ISSUE: begin
                if (!busy_s && tmo_cnt == TMO_LAST) begin
                    finish      = 1'b1;
                    res_timeout = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    finish = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    finish      = 1'b1;
                    res_timeout = 1'b1;
                end
            end
            default: ;
        endcase
        res_data   = (own_write || res_timeout) ? '0 : SWDoutputData;
        res_parity = !own_write && !res_timeout && SWDoutputParity;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy_meta    <= 1'b0;
            busy_s       <= 1'b0;
            burst_cnt    <= '0;
            tmo_cnt      <= '0;
            own_write    <= 1'b0;
            rxReq        <= 1'b0;
            txReq        <= 1'b0;
            useParity    <= 1'b0;
            bits         <= '0;
            SWDinputData <= '0;
            owner        <= 1'b0;
            active       <= 1'b0;
            h_ack        <= 1'b0;
            h_rdata      <= '0;
            h_rparity    <= 1'b0;
            h_timeout    <= 1'b0;
            p_ack        <= 1'b0;
            p_rdata      <= '0;
            p_rparity    <= 1'b0;
            p_timeout    <= 1'b0;
        end else begin
            busy_meta <= SWDbusy;
            busy_s    <= busy_meta;
            h_ack     <= 1'b0;
            p_ack     <= 1'b0;

            if (finish) begin
                rxReq <= 1'b0;
                txReq <= 1'b0;
                state <= COMPLETE;
                if (owner) begin
                    p_ack     <= 1'b1;
                    p_rdata   <= res_data;
                    p_rparity <= res_parity;
                    p_timeout <= res_timeout;
                end else begin
                    h_ack     <= 1'b1;
                    h_rdata   <= res_data;
                    h_rparity <= res_parity;
                    h_timeout <= res_timeout;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (h_req || p_req) begin
                            owner   <= grant_poller;
                            active  <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= ISSUE;
                            if (grant_poller) begin
                                bits         <= p_bits;
                                useParity    <= p_useParity;
                                SWDinputData <= p_wdata;
                                own_write    <= p_write;
                                txReq        <= p_write;
                                rxReq        <= !p_write;
                                burst_cnt    <= '0;
                            end else begin
                                bits         <= h_bits;
                                useParity    <= h_useParity;
                                SWDinputData <= h_wdata;
                                own_write    <= h_write;
                                txReq        <= h_write;
                                rxReq        <= !h_write;
                                if (!p_req) begin
                                    burst_cnt <= '0;
                                end else if (burst_cnt != '1) begin
                                    burst_cnt <= burst_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    ISSUE: begin
                        if (busy_s) begin
                            rxReq   <= 1'b0;
                            txReq   <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= WAIT_DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    WAIT_DONE: begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                    COMPLETE: begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
